// File: rtl/mem_access_unit.sv
// Data-memory access stage: turns EX/MEM control into a single-outstanding bus
// transaction and produces the write-back bundle (load data, address faults).
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_dmen_i,
    input  logic        mem_memwr_i,
    input  logic        mem_memtoreg_i,
    input  logic        mem_regwr_i,
    input  logic [1:0]  mem_dm_type_i,
    input  logic        mem_dm_extsigned_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_rt_i,
    input  logic [4:0]  mem_regdst_addr_i,
    input  logic [31:0] mem_pc_i,
    output logic        dbus_req_o,
    output logic        dbus_wr_o,
    output logic [31:0] dbus_addr_o,
    output logic [3:0]  dbus_be_o,
    output logic [31:0] dbus_wdata_o,
    input  logic [31:0] dbus_rdata_i,
    input  logic        dbus_ack_i,
    output logic        mem_stall_o,
    output logic        wb_regwr_o,
    output logic [4:0]  wb_regdst_addr_o,
    output logic [31:0] wb_data_o,
    output logic [31:0] wb_pc_o,
    output logic        wb_adel_o,
    output logic        wb_ades_o,
    output logic [31:0] wb_badvaddr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Transaction captured on entry to BUSY
    logic        r_dbus_wr;
    logic [31:0] r_dbus_addr;
    logic [3:0]  r_dbus_be;
    logic [31:0] r_dbus_wdata;
    logic [1:0]  r_type;
    logic [1:0]  r_off;
    logic        r_ext;
    logic        r_memtoreg;
    logic        r_regwr;
    logic [4:0]  r_regdst;
    logic [31:0] r_pc;
    logic [31:0] r_result;
    logic [31:0] r_ld_data;

    // Write-back registers
    logic        r_wb_regwr;
    logic [4:0]  r_wb_regdst;
    logic [31:0] r_wb_data;
    logic [31:0] r_wb_pc;
    logic        r_wb_adel;
    logic        r_wb_ades;
    logic [31:0] r_wb_badvaddr;

    logic        w_misaligned;
    logic        w_access;
    logic        w_fault_ld;
    logic        w_fault_st;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata;
    logic [31:0] w_pass_ld_data;
    logic        w_stall;
    logic        w_req;
    logic        w_capture;
    logic        w_pass;
    logic        w_done;

    function automatic logic [31:0] fmt_load(
        input logic [31:0] rdata,
        input logic [1:0]  dm_type,
        input logic [1:0]  off,
        input logic        ext
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = off[1] ? rdata[31:16] : rdata[15:0];
        case (dm_type)
            2'b00:   res = {{24{ext & b[7]}}, b};
            2'b01:   res = {{16{ext & h[15]}}, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Reserved type 11 behaves as a word access, including alignment
    assign w_misaligned = ((mem_dm_type_i == 2'b01) && mem_result_i[0]) ||
                          (mem_dm_type_i[1] && (mem_result_i[1:0] != 2'b00));
    assign w_access     = mem_dmen_i && !w_misaligned;
    assign w_fault_ld   = mem_dmen_i && w_misaligned && !mem_memwr_i;
    assign w_fault_st   = mem_dmen_i && w_misaligned && mem_memwr_i;

    always_comb begin
        w_st_be    = 4'b1111;
        w_st_wdata = mem_rt_i;
        case (mem_dm_type_i)
            2'b00: begin
                w_st_be    = 4'b0001 << mem_result_i[1:0];
                w_st_wdata = {4{mem_rt_i[7:0]}};
            end
            2'b01: begin
                w_st_be    = mem_result_i[1] ? 4'b1100 : 4'b0011;
                w_st_wdata = {2{mem_rt_i[15:0]}};
            end
            default: begin
                w_st_be    = 4'b1111;
                w_st_wdata = mem_rt_i;
            end
        endcase
    end

    assign w_pass_ld_data = fmt_load(dbus_rdata_i, mem_dm_type_i,
                                     mem_result_i[1:0], mem_dm_extsigned_i);

    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_req        = 1'b0;
        w_capture    = 1'b0;
        w_pass       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_stall      = 1'b1;
                    w_capture    = 1'b1;
                    w_state_next = S_BUSY;
                end else begin
                    w_pass = 1'b1;
                end
            end
            S_BUSY: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (dbus_ack_i) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dbus_wr    <= 1'b0;
            r_dbus_addr  <= 32'd0;
            r_dbus_be    <= 4'd0;
            r_dbus_wdata <= 32'd0;
            r_type       <= 2'd0;
            r_off        <= 2'd0;
            r_ext        <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_regwr      <= 1'b0;
            r_regdst     <= 5'd0;
            r_pc         <= 32'd0;
            r_result     <= 32'd0;
        end else if (w_capture) begin
            r_dbus_wr    <= mem_memwr_i;
            r_dbus_addr  <= {mem_result_i[31:2], 2'b00};
            r_dbus_be    <= w_st_be;
            r_dbus_wdata <= w_st_wdata;
            r_type       <= mem_dm_type_i;
            r_off        <= mem_result_i[1:0];
            r_ext        <= mem_dm_extsigned_i;
            r_memtoreg   <= mem_memtoreg_i;
            r_regwr      <= mem_regwr_i;
            r_regdst     <= mem_regdst_addr_i;
            r_pc         <= mem_pc_i;
            r_result     <= mem_result_i;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_data <= 32'd0;
        end else if ((r_state == S_BUSY) && dbus_ack_i) begin
            r_ld_data <= fmt_load(dbus_rdata_i, r_type, r_off, r_ext);
        end
    end

    // WB bundle: pass-through from IDLE, or the held access once it completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_regwr    <= 1'b0;
            r_wb_regdst   <= 5'd0;
            r_wb_data     <= 32'd0;
            r_wb_pc       <= 32'd0;
            r_wb_adel     <= 1'b0;
            r_wb_ades     <= 1'b0;
            r_wb_badvaddr <= 32'd0;
        end else if (w_pass) begin
            r_wb_regwr    <= mem_regwr_i && !(w_fault_ld || w_fault_st);
            r_wb_regdst   <= mem_regdst_addr_i;
            r_wb_data     <= mem_memtoreg_i ? w_pass_ld_data : mem_result_i;
            r_wb_pc       <= mem_pc_i;
            r_wb_adel     <= w_fault_ld;
            r_wb_ades     <= w_fault_st;
            r_wb_badvaddr <= (w_fault_ld || w_fault_st) ? mem_result_i : 32'd0;
        end else if (w_done) begin
            r_wb_regwr    <= r_regwr;
            r_wb_regdst   <= r_regdst;
            r_wb_data     <= r_memtoreg ? r_ld_data : r_result;
            r_wb_pc       <= r_pc;
            r_wb_adel     <= 1'b0;
            r_wb_ades     <= 1'b0;
            r_wb_badvaddr <= 32'd0;
        end
    end

    assign mem_stall_o      = w_stall;
    assign dbus_req_o       = w_req;
    assign dbus_wr_o        = r_dbus_wr;
    assign dbus_addr_o      = r_dbus_addr;
    assign dbus_be_o        = r_dbus_be;
    assign dbus_wdata_o     = r_dbus_wdata;
    assign wb_regwr_o       = r_wb_regwr;
    assign wb_regdst_addr_o = r_wb_regdst;
    assign wb_data_o        = r_wb_data;
    assign wb_pc_o          = r_wb_pc;
    assign wb_adel_o        = r_wb_adel;
    assign wb_ades_o        = r_wb_ades;
    assign wb_badvaddr_o    = r_wb_badvaddr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Random + directed bench for mem_access_unit: a byte-level memory model predicts
// each WB bundle, a bus responder serves requests, a monitor scores WB updates.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_dmen_i, mem_memwr_i, mem_memtoreg_i, mem_regwr_i;
    logic [1:0]  mem_dm_type_i;
    logic        mem_dm_extsigned_i;
    logic [31:0] mem_result_i, mem_rt_i, mem_pc_i;
    logic [4:0]  mem_regdst_addr_i;
    logic        dbus_req_o, dbus_wr_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_rdata_i = 32'd0;
    logic        dbus_ack_i = 1'b0;
    logic        mem_stall_o;
    logic        wb_regwr_o;
    logic [4:0]  wb_regdst_addr_o;
    logic [31:0] wb_data_o, wb_pc_o, wb_badvaddr_o;
    logic        wb_adel_o, wb_ades_o;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .mem_dmen_i(mem_dmen_i), .mem_memwr_i(mem_memwr_i),
        .mem_memtoreg_i(mem_memtoreg_i), .mem_regwr_i(mem_regwr_i),
        .mem_dm_type_i(mem_dm_type_i), .mem_dm_extsigned_i(mem_dm_extsigned_i),
        .mem_result_i(mem_result_i), .mem_rt_i(mem_rt_i),
        .mem_regdst_addr_i(mem_regdst_addr_i), .mem_pc_i(mem_pc_i),
        .dbus_req_o(dbus_req_o), .dbus_wr_o(dbus_wr_o), .dbus_addr_o(dbus_addr_o),
        .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
        .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i),
        .mem_stall_o(mem_stall_o),
        .wb_regwr_o(wb_regwr_o), .wb_regdst_addr_o(wb_regdst_addr_o),
        .wb_data_o(wb_data_o), .wb_pc_o(wb_pc_o),
        .wb_adel_o(wb_adel_o), .wb_ades_o(wb_ades_o), .wb_badvaddr_o(wb_badvaddr_o)
    );

    typedef struct {
        bit          dmen, wr, m2r, regwr;
        logic [1:0]  typ;
        bit          ext;
        logic [31:0] addr, rt, pc;
        logic [4:0]  dst;
    } ins_t;

    typedef struct {
        logic        regwr;
        logic [4:0]  dst;
        logic [31:0] data, pc, badv;
        logic        adel, ades;
        bit          chk_data;
        bit          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          exp_bus = 0;
    logic [31:0] ref_mem[64];
    logic [31:0] bus_mem[64];
    bit          mon_en = 0;

    // Bus responder state
    int          fixed_wait = -1;
    int          wait_left = 0;
    bit          resp_busy = 0;
    bit          inject_ack = 0;
    int          bus_count = 0;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] s;
        s = ref_mem[a[7:2]] >> (8 * a[1:0]);
        return s[7:0];
    endfunction

    // Reference model: byte-addressed little-endian memory, sizes 1/2/4
    function automatic exp_t model(input ins_t in);
        exp_t        e;
        int          sz;
        logic [31:0] val, a, w, sh;
        sz = (in.typ == 2'b00) ? 1 : ((in.typ == 2'b01) ? 2 : 4);
        e.dst  = in.dst;
        e.pc   = in.pc;
        e.data = in.addr;
        e.acc  = 0;
        if (in.dmen && ((in.addr % sz) != 0)) begin
            e.regwr = 0; e.adel = !in.wr; e.ades = in.wr;
            e.badv = in.addr; e.chk_data = 0;
        end else begin
            e.regwr = in.regwr; e.adel = 0; e.ades = 0;
            e.badv = 32'd0; e.chk_data = 1;
            e.acc = in.dmen;
            if (in.dmen && in.wr) begin
                for (int k = 0; k < sz; k++) begin
                    a  = in.addr + 32'(k);
                    w  = ref_mem[a[7:2]];
                    sh = in.rt >> (8 * k);
                    w[8 * a[1:0] +: 8] = sh[7:0];
                    ref_mem[a[7:2]] = w;
                end
            end else if (in.dmen) begin
                val = 32'd0;
                for (int k = 0; k < sz; k++)
                    val = val | (32'(ref_byte(in.addr + 32'(k))) << (8 * k));
                if (in.ext && sz < 4 && val[8 * sz - 1])
                    val = val | (32'hFFFF_FFFF << (8 * sz));
                if (in.m2r) e.data = val;
            end
        end
        return e;
    endfunction

    function automatic ins_t alu(input logic [31:0] res, input logic [4:0] dst,
                                 input bit regwr);
        ins_t in;
        in = '{dmen: 0, wr: 0, m2r: 0, regwr: regwr, typ: 2'b00, ext: 0,
               addr: res, rt: $urandom, pc: $urandom, dst: dst};
        return in;
    endfunction

    function automatic ins_t mop(input bit wr, input logic [1:0] typ, input bit ext,
                                 input logic [31:0] addr, input logic [31:0] rt,
                                 input logic [4:0] dst);
        ins_t in;
        in = '{dmen: 1, wr: wr, m2r: !wr, regwr: !wr, typ: typ, ext: ext,
               addr: addr, rt: rt, pc: $urandom, dst: dst};
        return in;
    endfunction

    task automatic drive(input ins_t in);
        mem_dmen_i = in.dmen; mem_memwr_i = in.wr; mem_memtoreg_i = in.m2r;
        mem_regwr_i = in.regwr; mem_dm_type_i = in.typ; mem_dm_extsigned_i = in.ext;
        mem_result_i = in.addr; mem_rt_i = in.rt; mem_pc_i = in.pc;
        mem_regdst_addr_i = in.dst;
    endtask

    task automatic summary_and_finish();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Called at a negedge; returns at a negedge once the instruction has retired
    task automatic issue(input ins_t in, output int stalls);
        exp_t e;
        e = model(in);
        drive(in);
        exp_q.push_back(e);
        if (e.acc) exp_bus++;
        #1;
        stalls = 0;
        while (mem_stall_o) begin
            stalls++;
            if (stalls > 40) begin
                n_tests++; n_fail++;
                $display("FAIL stall_timeout: got %0d stall cycles expected <= 40", stalls);
                summary_and_finish();
            end
            @(negedge clk);
            #1;
        end
        if (e.acc) chk("stall_access", 32'(stalls >= 2), 32'd1);
        else       chk("stall_none", 32'(stalls), 32'd0);
        @(negedge clk);
    endtask

    // Bus responder
    always @(negedge clk) begin
        if (inject_ack) begin
            dbus_ack_i   = 1'b1;
            dbus_rdata_i = 32'h5A5A_5A5A;
            inject_ack   = 0;
            resp_busy    = 0;
        end else if (dbus_req_o) begin
            if (!resp_busy) begin
                resp_busy = 1;
                bus_count++;
                last_addr = dbus_addr_o; last_be = dbus_be_o;
                last_wdata = dbus_wdata_o; last_wr = dbus_wr_o;
                wait_left = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
            end
            if (wait_left == 0) begin
                dbus_ack_i   = 1'b1;
                dbus_rdata_i = bus_mem[dbus_addr_o[7:2]];
                if (dbus_wr_o)
                    for (int l = 0; l < 4; l++)
                        if (dbus_be_o[l])
                            bus_mem[dbus_addr_o[7:2]][8 * l +: 8] = dbus_wdata_o[8 * l +: 8];
            end else begin
                dbus_ack_i   = 1'b0;
                dbus_rdata_i = $urandom;
                wait_left--;
            end
        end else begin
            dbus_ack_i   = 1'b0;
            dbus_rdata_i = $urandom;
            resp_busy    = 0;
        end
    end

    // Monitor: a WB update happens on every edge where the stage is not stalled
    always @(posedge clk) begin
        bit   upd;
        exp_t e;
        upd = mon_en && reset && !mem_stall_o;
        #1;
        if (upd) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL wb_unexpected: got update pc 0x%08h expected none", wb_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("wb_regwr", 32'(wb_regwr_o), 32'(e.regwr));
                chk("wb_regdst", 32'(wb_regdst_addr_o), 32'(e.dst));
                chk("wb_pc", wb_pc_o, e.pc);
                chk("wb_adel", 32'(wb_adel_o), 32'(e.adel));
                chk("wb_ades", 32'(wb_ades_o), 32'(e.ades));
                chk("wb_badvaddr", wb_badvaddr_o, e.badv);
                if (e.chk_data) chk("wb_data", wb_data_o, e.data);
            end
        end
    end

    initial begin
        int          st;
        int          bc;
        ins_t        in;
        logic [31:0] v;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            bus_mem[i] = v;
        end
        drive(alu(32'd0, 5'd0, 0));
        mem_pc_i = 32'd0; mem_rt_i = 32'd0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        chk("rst_req", 32'(dbus_req_o), 32'd0);
        chk("rst_dbus_addr", dbus_addr_o, 32'd0);
        chk("rst_dbus_be", 32'(dbus_be_o), 32'd0);
        chk("rst_dbus_wdata", dbus_wdata_o, 32'd0);
        chk("rst_wb_regwr", 32'(wb_regwr_o), 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        chk("rst_wb_badv", wb_badvaddr_o, 32'd0);
        chk("rst_stall", 32'(mem_stall_o), 32'd0);
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        mon_en = 1;

        // ALU pass-through
        issue(alu(32'h1234_5678, 5'd5, 1), st);

        // Signed lb at 0x103, ack on first BUSY cycle
        ref_mem[32'h103 >> 2] = 32'h80AA_BBCC;
        bus_mem[32'h103 >> 2] = 32'h80AA_BBCC;
        fixed_wait = 0;
        issue(mop(0, 2'b00, 1, 32'h103, 32'd0, 5'd7), st);
        chk("lb_stall_cycles", 32'(st), 32'd2);

        // sh at 0x202
        issue(mop(1, 2'b01, 0, 32'h202, 32'h1234_ABCD, 5'd0), st);
        chk("sh_addr", last_addr, 32'h200);
        chk("sh_be", 32'(last_be), 32'b1100);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        chk("sh_wr", 32'(last_wr), 32'd1);

        // lw at 0x40, ack on third BUSY cycle
        ref_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        bus_mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        fixed_wait = 2;
        issue(mop(0, 2'b10, 0, 32'h40, 32'd0, 5'd8), st);
        chk("lw_stall_cycles", 32'(st), 32'd4);

        // Misaligned lh: no bus access, fault reported
        fixed_wait = -1;
        bc = bus_count;
        issue(mop(0, 2'b01, 1, 32'h101, 32'd0, 5'd9), st);
        chk("lh_mis_bus", 32'(bus_count), 32'(bc));

        // Randomized mix
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0: in = alu($urandom, 5'($urandom), 1'($urandom));
                1: in = mop(0, 2'($urandom), 1'($urandom), $urandom, 32'd0, 5'($urandom));
                default: in = mop(1, 2'($urandom), 0, $urandom, $urandom, 5'($urandom));
            endcase
            if (in.dmen && $urandom_range(0, 3) != 0)
                in.addr[1:0] = in.addr[1:0] & ((in.typ == 2'b00) ? 2'b11 :
                                               (in.typ == 2'b01) ? 2'b10 : 2'b00);
            issue(in, st);
        end

        // Reset in the middle of a BUSY wait, then a late ack
        fixed_wait = 100;
        drive(mop(0, 2'b10, 0, 32'h80, 32'd0, 5'd3));
        exp_bus++;
        @(negedge clk);
        #1;
        chk("busy_req", 32'(dbus_req_o), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_busy_req", 32'(dbus_req_o), 32'd0);
        chk("rst_busy_wb_regwr", 32'(wb_regwr_o), 32'd0);
        chk("rst_busy_wb_data", wb_data_o, 32'd0);
        chk("rst_busy_dbus_addr", dbus_addr_o, 32'd0);
        drive(alu(32'd0, 5'd0, 0));
        @(negedge clk);
        reset      = 1'b1;
        inject_ack = 1;
        fixed_wait = -1;
        issue(alu(32'h0000_0077, 5'd9, 1), st);
        issue(alu(32'hCAFE_0001, 5'd10, 1), st);
        issue(mop(0, 2'b00, 0, 32'h81, 32'd0, 5'd11), st);

        drive(alu(32'd0, 5'd0, 0));
        mon_en = 0;
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("bus_count", 32'(bus_count), 32'(exp_bus));
        summary_and_finish();
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low (0 = reset).
REQ-003 SHALL have: mem_dmen_i, mem_memwr_i, mem_memtoreg_i, mem_regwr_i  in  1 each  control from EX/MEM stage.
REQ-004 SHALL have: mem_dm_type_i  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word); mem_dm_extsigned_i  in  1  1 = sign-extend loads.
REQ-005 SHALL have: mem_result_i  in  32  ALU result / effective address; mem_rt_i  in  32  store data; mem_regdst_addr_i  in  5; mem_pc_i  in  32.
REQ-006 SHALL have: dbus_req_o, dbus_wr_o  out  1; dbus_addr_o  out  32  word-aligned; dbus_be_o  out  4; dbus_wdata_o  out  32; dbus_rdata_i  in  32; dbus_ack_i  in  1.
REQ-007 SHALL have: mem_stall_o  out  1  holds upstream (drives pa_idexmemwr) when 1.
REQ-008 SHALL have: wb_regwr_o  out  1; wb_regdst_addr_o  out  5; wb_data_o  out  32; wb_pc_o  out  32; wb_adel_o, wb_ades_o  out  1  load/store address error; wb_badvaddr_o  out  32.

Function
REQ-009 SHALL implement FSM IDLE, BUSY, DONE; reset state IDLE.
REQ-010 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00; SHALL never issue a bus access for it.
REQ-011 IDLE, mem_dmen_i=1 and aligned: mem_stall_o=1 (combinational); at edge capture dbus_addr={addr[31:2],00}, be, wdata, wr=mem_memwr_i; go BUSY.
REQ-012 BUSY: dbus_req_o=1, mem_stall_o=1; on dbus_ack_i=1 at edge, latch formatted load data internally, go DONE; otherwise stay BUSY (unbounded wait states).
REQ-013 DONE: dbus_req_o=0, mem_stall_o=0; at edge load WB outputs from held instruction, go IDLE.
REQ-014 dbus_req_o SHALL be 0 outside BUSY; dbus_ack_i outside BUSY SHALL be ignored.
REQ-015 IDLE with mem_dmen_i=0, or misaligned: mem_stall_o=0; WB outputs load at every edge (single-cycle pass-through).
REQ-016 wb_data_o = formatted load data if mem_memtoreg_i=1, else mem_result_i.
REQ-017 Load byte: lane addr[1:0] (little-endian, lane 0 = bits 7:0); half: lane addr[1]; extend per mem_dm_extsigned_i; word unmodified.
REQ-018 Store byte: wdata={4{rt[7:0]}}, be=0001<<addr[1:0]; half: wdata={2{rt[15:0]}}, be=addr[1]?1100:0011; word: rt, be=1111.
REQ-019 Misaligned load: wb_adel_o=1; misaligned store: wb_ades_o=1; both set wb_badvaddr_o=mem_result_i and force wb_regwr_o=0.
REQ-020 Non-faulting instructions: wb_adel_o=wb_ades_o=0, wb_badvaddr_o=0, wb_regwr_o=mem_regwr_i.
REQ-021 Memory access latency: min 3 cycles (IDLE, BUSY with ack, DONE); each extra non-ack BUSY cycle adds one.

Reset
REQ-022 reset=0 SHALL immediately (without clock) force state IDLE, all dbus_* outputs 0, all wb_* outputs 0; mem_stall_o then follows REQ-011/015.
REQ-023 Reset asserted in BUSY SHALL abandon the access; a late dbus_ack_i after release SHALL be ignored.

Verification
REQ-024 Signed lb, addr 0x103, rdata 0x80AABBCC, ack first BUSY cycle -> stall 2 cycles, wb_data_o=0xFFFFFF80 after DONE edge.
REQ-025 sh, addr 0x202, rt 0x1234ABCD -> dbus_addr_o 0x200, be 1100, wdata 0xABCDABCD, wr=1, wb_regwr_o=0.
REQ-026 lw, addr 0x40, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> stall high 4 cycles, low in DONE, wb_data_o 0xDEADBEEF.
REQ-027 lh, addr 0x101 -> no dbus_req_o, no stall, wb_adel_o=1, wb_badvaddr_o=0x101, wb_regwr_o=0.
REQ-028 reset=0 mid-BUSY -> dbus_req_o drops same cycle, state IDLE; ack next cycle -> no WB update.
REQ-029 ALU op, result 0x12345678, regwr 1, dst 5 -> next edge wb_data_o 0x12345678, wb_regdst_addr_o 5, no stall.
